otter_ex_issue: RTL

//  ID/EX pipeline register and operand-select stage of the pipelined OTTER MCU; sits directly upstream of the ALU.

---
 rtl/otter_ex_issue_if.sv | 59 +++++
 rtl/otter_ex_issue.sv | 132 +++++++++++++
 2 files changed

// File: rtl/otter_ex_issue_if.sv
// ID/EX issue bundle: decode-side handshake, operands, forwarding
// sources, and the EX-side handshake with ALU operands.
// master = upstream/environment view, slave = issue-stage view.
interface otter_ex_issue_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic             id_ready;
   logic [4:0]       id_rs1_addr;
   logic [4:0]       id_rs2_addr;
   logic [XLEN-1:0]  id_rs1_data;
   logic [XLEN-1:0]  id_rs2_data;
   logic [XLEN-1:0]  id_imm;
   logic [XLEN-1:0]  id_pc;
   logic [1:0]       id_srcA_sel;
   logic [1:0]       id_srcB_sel;
   logic [3:0]       id_alu_fun;
   logic [4:0]       id_rd_addr;
   logic             id_rd_we;
   logic             flush;
   logic [4:0]       mem_rd_addr;
   logic             mem_rd_we;
   logic             mem_is_load;
   logic [XLEN-1:0]  mem_result;
   logic [4:0]       wb_rd_addr;
   logic             wb_rd_we;
   logic [XLEN-1:0]  wb_result;
   logic             ex_ready;
   logic             ex_valid;
   logic [XLEN-1:0]  srcA;
   logic [XLEN-1:0]  srcB;
   logic [3:0]       alu_fun;
   logic [4:0]       ex_rd_addr;
   logic             ex_rd_we;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs1_addr, id_rs2_addr,
      output id_rs1_data, id_rs2_data, id_imm, id_pc,
      output id_srcA_sel, id_srcB_sel, id_alu_fun,
      output id_rd_addr, id_rd_we, flush,
      output mem_rd_addr, mem_rd_we, mem_is_load, mem_result,
      output wb_rd_addr, wb_rd_we, wb_result, ex_ready,
      input  id_ready, ex_valid, srcA, srcB, alu_fun,
      input  ex_rd_addr, ex_rd_we, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1_addr, id_rs2_addr,
      input  id_rs1_data, id_rs2_data, id_imm, id_pc,
      input  id_srcA_sel, id_srcB_sel, id_alu_fun,
      input  id_rd_addr, id_rd_we, flush,
      input  mem_rd_addr, mem_rd_we, mem_is_load, mem_result,
      input  wb_rd_addr, wb_rd_we, wb_result, ex_ready,
      output id_ready, ex_valid, srcA, srcB, alu_fun,
      output ex_rd_addr, ex_rd_we, stall_cnt
   );
endinterface

// File: rtl/otter_ex_issue.sv
// OTTER ID/EX hold register + operand select, forwarding, load-use stall.
// Ports: CLK, RST_N (async active-low), bus (otter_ex_issue_if.slave).
// Macro OTTER_EX_FWD_EN: MEM/WB forwarding; otherwise stall on any match.
module otter_ex_issue #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic             CLK,
   input logic             RST_N,
   otter_ex_issue_if.slave bus
);
   typedef struct packed {
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [1:0]      a_sel;
      logic [1:0]      b_sel;
      logic [3:0]      alu_fun;
      logic [4:0]      rd_addr;
      logic            rd_we;
   } hold_t;

   hold_t            hold_q, hold_d;
   logic             v_q, v_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic            mem_m1, mem_m2, wb_m1, wb_m2;
   logic            use1, use2, hazard;
   logic            ex_valid, ex_fire, id_ready, capture;
   logic [XLEN-1:0] rs1_val, rs2_val, src_a, src_b;

   // Matches use the registered index; x0 never matches.
   always_comb begin
      mem_m1 = bus.mem_rd_we && (hold_q.rs1_addr != 5'd0)
               && (hold_q.rs1_addr == bus.mem_rd_addr);
      mem_m2 = bus.mem_rd_we && (hold_q.rs2_addr != 5'd0)
               && (hold_q.rs2_addr == bus.mem_rd_addr);
      wb_m1  = bus.wb_rd_we && (hold_q.rs1_addr != 5'd0)
               && (hold_q.rs1_addr == bus.wb_rd_addr);
      wb_m2  = bus.wb_rd_we && (hold_q.rs2_addr != 5'd0)
               && (hold_q.rs2_addr == bus.wb_rd_addr);
      use1   = (hold_q.a_sel == 2'b00);
      use2   = (hold_q.b_sel == 2'b00);
`ifdef OTTER_EX_FWD_EN
      hazard  = v_q && bus.mem_is_load
                && ((use1 && mem_m1) || (use2 && mem_m2));
      rs1_val = mem_m1 ? bus.mem_result
              : (wb_m1 ? bus.wb_result : hold_q.rs1_data);
      rs2_val = mem_m2 ? bus.mem_result
              : (wb_m2 ? bus.wb_result : hold_q.rs2_data);
`else
      hazard  = v_q && ((use1 && (mem_m1 || wb_m1))
                || (use2 && (mem_m2 || wb_m2)));
      rs1_val = hold_q.rs1_data;
      rs2_val = hold_q.rs2_data;
`endif
   end

`ifndef OTTER_EX_FWD_EN
   logic unused_fwd;
   assign unused_fwd = ^{bus.mem_result, bus.wb_result, bus.mem_is_load};
`endif

   assign ex_valid = v_q && !hazard;
   assign ex_fire  = ex_valid && bus.ex_ready;
   assign id_ready = !v_q || ex_fire;
   assign capture  = bus.id_valid && id_ready;

   always_comb begin
      case (hold_q.a_sel)
         2'b00:   src_a = rs1_val;
         2'b01:   src_a = hold_q.imm;
         2'b10:   src_a = hold_q.pc;
         default: src_a = '0;
      endcase
      case (hold_q.b_sel)
         2'b00:   src_b = rs2_val;
         2'b01:   src_b = hold_q.imm;
         2'b10:   src_b = hold_q.pc;
         default: src_b = {{(XLEN-3){1'b0}}, 3'b100};
      endcase
   end

   // Flush wins over a same-cycle capture.
   always_comb begin
      hold_d = hold_q;
      if (capture) begin
         hold_d.rs1_addr = bus.id_rs1_addr;
         hold_d.rs2_addr = bus.id_rs2_addr;
         hold_d.rs1_data = bus.id_rs1_data;
         hold_d.rs2_data = bus.id_rs2_data;
         hold_d.imm      = bus.id_imm;
         hold_d.pc       = bus.id_pc;
         hold_d.a_sel    = bus.id_srcA_sel;
         hold_d.b_sel    = bus.id_srcB_sel;
         hold_d.alu_fun  = bus.id_alu_fun;
         hold_d.rd_addr  = bus.id_rd_addr;
         hold_d.rd_we    = bus.id_rd_we;
      end
      if (bus.flush)     v_d = 1'b0;
      else if (capture)  v_d = 1'b1;
      else if (ex_fire)  v_d = 1'b0;
      else               v_d = v_q;
      stall_cnt_d = stall_cnt_q;
      if (hazard && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         v_q         <= 1'b0;
         hold_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         v_q         <= v_d;
         hold_q      <= hold_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.id_ready   = id_ready;
   assign bus.ex_valid   = ex_valid;
   assign bus.srcA       = src_a;
   assign bus.srcB       = src_b;
   assign bus.alu_fun    = hold_q.alu_fun;
   assign bus.ex_rd_addr = hold_q.rd_addr;
   assign bus.ex_rd_we   = hold_q.rd_we;
   assign bus.stall_cnt  = stall_cnt_q;
endmodule
